// File: rtl/lab4_net_bus_pkg.sv
// rtl/lab4_net_bus_pkg.sv - shared types and index helpers for the bus network control unit
package lab4_net_bus_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} bus_state_t;

  // Widest supported terminal count; helpers operate on vectors zero-extended to this width
  localparam int unsigned MAX_PORTS = 16;

  // (idx + 1) mod n, for idx already in 0..n-1
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Index of the set bit of a one-hot vector (0 when no bit is set)
  function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) r = int'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/lab4_net_rr_arb_en.sv
// rtl/lab4_net_rr_arb_en.sv - round-robin arbiter whose pointer moves only when en is pulsed
module lab4_net_rr_arb_en
  import lab4_net_bus_pkg::*;
#(
  parameter int NPORTS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] reqs,
  input  logic              en,
  output logic [NPORTS-1:0] grants
);

  logic [NPORTS-1:0] prio_q;
  int unsigned       pidx;
  int unsigned       idx;
  logic              found;

  // Search requests starting at the priority pointer, wrapping at NPORTS
  always_comb begin
    grants = '0;
    found  = 1'b0;
    idx    = 0;
    pidx   = onehot_to_idx(MAX_PORTS'(prio_q));
    for (int k = 0; k < NPORTS; k++) begin
      idx = pidx + int'(k);
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && reqs[idx]) begin
        grants[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Pointer moves to the port just after the current grant when a packet ends or is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= NPORTS'(1);
    end else if (en && (|grants)) begin
      prio_q <= NPORTS'(1) << next_idx(onehot_to_idx(MAX_PORTS'(grants)), NPORTS);
    end
  end

endmodule

// File: rtl/lab4_net_bus_net_ctrl_burst.sv
// rtl/lab4_net_bus_net_ctrl_burst.sv - shared-bus burst control: arbitration, packet lock, port valid/ready (option LAB4_NET_BUS_CTRL_STATS_EN adds xfer_cnt)
module lab4_net_bus_net_ctrl_burst
  import lab4_net_bus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DW     = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    inq_val,
  output logic [NPORTS-1:0]    inq_rdy,
  input  logic [NPORTS*DW-1:0] inq_dest,
  input  logic [NPORTS-1:0]    inq_tail,
  output logic [NPORTS-1:0]    out_val,
  input  logic [NPORTS-1:0]    out_rdy,
  output logic [DW-1:0]        sel
`ifdef LAB4_NET_BUS_CTRL_STATS_EN
  ,
  output logic [31:0]          xfer_cnt
`endif
);

  bus_state_t        st, st_n;
  logic [DW-1:0]     owner_q, owner_n;
  logic [DW-1:0]     dest_q, dest_n;
  logic [NPORTS-1:0] reqs;
  logic [NPORTS-1:0] grants;
  int unsigned       owner_i;
  logic              owner_val;
  logic [DW-1:0]     dest;
  logic              legal;
  logic              rdy_dest;
  logic              tail;
  logic              xfer;
  logic              drop;
  logic              arb_en;

  // While locked only the owner may compete, so the arbiter grant is the owner exactly when it is valid
  always_comb begin
    reqs = inq_val;
    if (st == LOCKED) reqs = inq_val & (NPORTS'(1) << owner_q);
  end

  lab4_net_rr_arb_en #(.NPORTS(NPORTS)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .reqs   (reqs),
    .en     (arb_en),
    .grants (grants)
  );

  // Resolve current owner, its destination, legality and the transfer/drop qualifiers
  always_comb begin
    owner_val = |grants;
    owner_i   = (st == LOCKED) ? 32'(owner_q) : onehot_to_idx(MAX_PORTS'(grants));
    dest      = (st == LOCKED) ? dest_q : inq_dest[owner_i*DW +: DW];
    legal     = 32'(dest) < NPORTS;
    rdy_dest  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (32'(dest) == i) rdy_dest = out_rdy[i];
    end
    tail   = inq_tail[owner_i];
    xfer   = owner_val && legal && rdy_dest;
    drop   = (st == IDLE) && owner_val && !legal;
    arb_en = (xfer && tail) || drop;
  end

  // Output decode: one output valid toward dest, dequeue strobe to the owner; all quiet in reset
  always_comb begin
    out_val = '0;
    inq_rdy = '0;
    sel     = '0;
    if (!reset) begin
      if (st == LOCKED) sel = owner_q;
      else if (owner_val) sel = DW'(owner_i);
      for (int i = 0; i < NPORTS; i++) begin
        if (owner_val && legal && (32'(dest) == i)) out_val[i] = 1'b1;
        if (owner_val && (owner_i == i)) inq_rdy[i] = legal ? rdy_dest : 1'b1;
      end
    end
  end

  // Next-state: lock on a transferred non-tail head, unlock on a transferred tail
  always_comb begin
    st_n    = st;
    owner_n = owner_q;
    dest_n  = dest_q;
    case (st)
      IDLE: begin
        if (xfer && !tail) begin
          st_n    = LOCKED;
          owner_n = DW'(owner_i);
          dest_n  = dest;
        end
      end
      LOCKED: begin
        if (xfer && tail) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  // State and lock registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      owner_q <= '0;
      dest_q  <= '0;
    end else begin
      st      <= st_n;
      owner_q <= owner_n;
      dest_q  <= dest_n;
    end
  end

`ifdef LAB4_NET_BUS_CTRL_STATS_EN
  // Count transferred flits; drops are excluded and the count wraps naturally
  always_ff @(posedge clk) begin
    if (reset) xfer_cnt <= '0;
    else if (xfer) xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lab4_net_bus_net_ctrl_burst.sv
// tb/tb_lab4_net_bus_net_ctrl_burst.sv - directed self-checking bench for the burst bus control unit
module tb_lab4_net_bus_net_ctrl_burst;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] val4, rdy4, tail4, oval4, ordy4;
  logic [7:0] dest4;
  logic [1:0] sel4;

  logic [2:0] val3, rdy3, tail3, oval3, ordy3;
  logic [5:0] dest3;
  logic [1:0] sel3;

`ifdef LAB4_NET_BUS_CTRL_STATS_EN
  logic [31:0] cnt4, cnt3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lab4_net_bus_net_ctrl_burst #(.NPORTS(4)) dut4 (
    .clk(clk), .reset(reset), .inq_val(val4), .inq_rdy(rdy4), .inq_dest(dest4),
    .inq_tail(tail4), .out_val(oval4), .out_rdy(ordy4), .sel(sel4)
`ifdef LAB4_NET_BUS_CTRL_STATS_EN
    , .xfer_cnt(cnt4)
`endif
  );

  lab4_net_bus_net_ctrl_burst #(.NPORTS(3)) dut3 (
    .clk(clk), .reset(reset), .inq_val(val3), .inq_rdy(rdy3), .inq_dest(dest3),
    .inq_tail(tail3), .out_val(oval3), .out_rdy(ordy3), .sel(sel3)
`ifdef LAB4_NET_BUS_CTRL_STATS_EN
    , .xfer_cnt(cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] s, input logic [3:0] ov, input logic [3:0] ir);
    chk({tag, ".sel"}, 32'(sel4), 32'(s));
    chk({tag, ".out_val"}, 32'(oval4), 32'(ov));
    chk({tag, ".inq_rdy"}, 32'(rdy4), 32'(ir));
  endtask

  task automatic chk3(input string tag, input logic [1:0] s, input logic [2:0] ov, input logic [2:0] ir);
    chk({tag, ".sel"}, 32'(sel3), 32'(s));
    chk({tag, ".out_val"}, 32'(oval3), 32'(ov));
    chk({tag, ".inq_rdy"}, 32'(rdy3), 32'(ir));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle
  task automatic mid();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    val4 = 4'b1111; tail4 = 4'b1111; dest4 = 8'b10_10_10_10; ordy4 = 4'b1111;
    val3 = 3'b000;  tail3 = 3'b111;  dest3 = 6'b0;           ordy3 = 3'b111;
    #1;
    mid();
    chk4("reset_hold", 2'd0, 4'b0000, 4'b0000);
    chk3("reset_hold3", 2'd0, 3'b000, 3'b000);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // 1: all request single-flit packets to dest 2 -> grants 0,1,2,3,0
    mid(); chk4("rr_g0", 2'd0, 4'b0100, 4'b0001);
    next_cycle(); mid(); chk4("rr_g1", 2'd1, 4'b0100, 4'b0010);
    next_cycle(); mid(); chk4("rr_g2", 2'd2, 4'b0100, 4'b0100);
    next_cycle(); mid(); chk4("rr_g3", 2'd3, 4'b0100, 4'b1000);
    next_cycle(); mid(); chk4("rr_wrap", 2'd0, 4'b0100, 4'b0001);
    next_cycle();

    // 2/3: pointer now at 1; src1 sends 3 flits to dest 3 while src0 and src2 request
    val4 = 4'b0111; tail4 = 4'b1101; dest4 = {2'd0, 2'd1, 2'd3, 2'd0};
    mid(); chk4("burst_head", 2'd1, 4'b1000, 4'b0010);
    next_cycle();
    dest4 = {2'd0, 2'd1, 2'd0, 2'd0};
    ordy4 = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      mid(); chk4($sformatf("stall_%0d", c), 2'd1, 4'b1000, 4'b0000);
      next_cycle();
    end
    ordy4 = 4'b1111;
    mid(); chk4("burst_body", 2'd1, 4'b1000, 4'b0010);
    next_cycle();
    tail4 = 4'b1111;
    mid(); chk4("burst_tail", 2'd1, 4'b1000, 4'b0010);
    next_cycle();
    mid(); chk4("after_burst", 2'd2, 4'b0010, 4'b0100);
    next_cycle();

    // 4: NPORTS=3 illegal dest on a non-tail head -> dropped, no lock, src1 next
    val4 = 4'b0000;
    val3 = 3'b011; tail3 = 3'b110; dest3 = {2'd0, 2'd1, 2'd3};
    mid(); chk3("drop", 2'd0, 3'b000, 3'b001);
    next_cycle();
    mid(); chk3("after_drop", 2'd1, 3'b010, 3'b010);
    next_cycle();
    val3 = 3'b000;

    // 5: pointer at 3; src3 starts a 4-flit packet, reset after its 2nd flit
    val4 = 4'b1111; tail4 = 4'b0000; dest4 = 8'b0;
    mid(); chk4("rst_head", 2'd3, 4'b0001, 4'b1000);
    next_cycle();
    mid(); chk4("rst_flit2", 2'd3, 4'b0001, 4'b1000);
    next_cycle();
    reset = 1'b1;
    mid(); chk4("rst_mid", 2'd0, 4'b0000, 4'b0000);
    next_cycle();
`ifdef LAB4_NET_BUS_CTRL_STATS_EN
    chk("cnt_reset", cnt4, 32'd0);
`endif
    reset = 1'b0;
    mid(); chk4("rst_after", 2'd0, 4'b0001, 4'b0001);
    next_cycle();
`ifdef LAB4_NET_BUS_CTRL_STATS_EN
    chk("cnt_one", cnt4, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
